// File: rtl/cpu_pipe_pkg.sv
// Constants and types shared by every handshaked CPU pipeline-stage instance
// (IF/ID, ID/EX, EX/MEM, MEM/WB).
package cpu_pipe_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_EXC_W = 2;
    localparam int DEFAULT_CNT_W = 16;

    // Exception code meaning "no exception".
    localparam int EXC_NONE = 0;

    localparam int NUM_SLOTS = 2;
    localparam int SLOT_MAIN = 0;
    localparam int SLOT_SKID = 1;

    typedef enum logic [1:0] {
        MAIN_HOLD,
        MAIN_LOAD_IN,
        MAIN_LOAD_SKID,
        MAIN_CLEAR
    } main_act_e;

endpackage

// File: rtl/pipe_slot.sv
// One storage slot of the skid stage: a valid bit plus a data register.
// Clear wins over load, and a cleared slot always holds zero data.
module pipe_slot #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    logic         valid_q;
    logic [W-1:0] data_q;

    always_ff @(posedge clk) begin
        if (clr_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Handshaked pipeline-stage register with a two-entry skid buffer, flush,
// sticky first-exception capture and a saturating back-pressure counter.
module pipe_stage_skid
    import cpu_pipe_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int EXC_W = DEFAULT_EXC_W,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [EXC_W-1:0] in_exc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [EXC_W-1:0] out_exc,
    output logic [1:0]       occupancy,
    output logic [EXC_W-1:0] first_exc,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int SLOT_W = WIDTH + EXC_W;
    localparam logic [EXC_W-1:0] EXC_ZERO = EXC_W'(EXC_NONE);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [NUM_SLOTS-1:0]             slot_load;
    logic [NUM_SLOTS-1:0]             slot_clr;
    logic [NUM_SLOTS-1:0]             slot_valid;
    logic [NUM_SLOTS-1:0][SLOT_W-1:0] slot_din;
    logic [NUM_SLOTS-1:0][SLOT_W-1:0] slot_dout;

    main_act_e        main_act;
    logic             skid_load;
    logic             squash;
    logic             accept;
    logic             retire;
    logic             skid_valid_d;
    logic             in_ready_q;
    logic             in_ready_d;
    logic [EXC_W-1:0] first_exc_q;
    logic [EXC_W-1:0] first_exc_d;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;

    assign squash = reset | flush;
    // A squashed cycle neither accepts nor retires; the flushed head is dropped.
    assign accept = in_valid & in_ready_q & ~squash;
    assign retire = slot_valid[SLOT_MAIN] & out_ready & ~squash;

    always_comb begin
        main_act  = MAIN_HOLD;
        skid_load = 1'b0;
        if (!squash) begin
            if (!slot_valid[SLOT_MAIN]) begin
                if (accept) main_act = MAIN_LOAD_IN;
            end else if (slot_valid[SLOT_SKID]) begin
                if (retire) main_act = MAIN_LOAD_SKID;
            end else if (retire) begin
                main_act = accept ? MAIN_LOAD_IN : MAIN_CLEAR;
            end else if (accept) begin
                skid_load = 1'b1;
            end
        end
    end

    always_comb begin
        slot_load = '0;
        slot_clr  = '0;
        slot_din  = '0;

        slot_load[SLOT_MAIN] = (main_act == MAIN_LOAD_IN) || (main_act == MAIN_LOAD_SKID);
        slot_clr[SLOT_MAIN]  = squash || (main_act == MAIN_CLEAR);
        slot_din[SLOT_MAIN]  = (main_act == MAIN_LOAD_SKID) ? slot_dout[SLOT_SKID]
                                                            : {in_exc, in_data};

        slot_load[SLOT_SKID] = skid_load;
        slot_clr[SLOT_SKID]  = squash || (main_act == MAIN_LOAD_SKID);
        slot_din[SLOT_SKID]  = {in_exc, in_data};
    end

    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
        pipe_slot #(
            .W(SLOT_W)
        ) u_slot (
            .clk    (clk),
            .clr_i  (slot_clr[gi]),
            .load_i (slot_load[gi]),
            .data_i (slot_din[gi]),
            .valid_o(slot_valid[gi]),
            .data_o (slot_dout[gi])
        );
    end

    // in_ready is the registered complement of next-cycle SKID occupancy, so
    // it never depends combinationally on out_ready.
    always_comb begin
        skid_valid_d = slot_valid[SLOT_SKID];
        if (slot_clr[SLOT_SKID]) begin
            skid_valid_d = 1'b0;
        end else if (slot_load[SLOT_SKID]) begin
            skid_valid_d = 1'b1;
        end
        in_ready_d = ~skid_valid_d;
    end

    always_comb begin
        first_exc_d = first_exc_q;
        stall_cnt_d = stall_cnt_q;
        if (squash) begin
            first_exc_d = EXC_ZERO;
            stall_cnt_d = '0;
        end else begin
            if (accept && (in_exc != EXC_ZERO) && (first_exc_q == EXC_ZERO)) begin
                first_exc_d = in_exc;
            end
            if (slot_valid[SLOT_MAIN] && !out_ready && (stall_cnt_q != CNT_MAX)) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            in_ready_q  <= 1'b1;
            first_exc_q <= EXC_ZERO;
            stall_cnt_q <= '0;
        end else begin
            in_ready_q  <= in_ready_d;
            first_exc_q <= first_exc_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign in_ready             = in_ready_q;
    assign out_valid            = slot_valid[SLOT_MAIN];
    assign {out_exc, out_data}  = slot_dout[SLOT_MAIN];
    assign occupancy            = {1'b0, slot_valid[SLOT_MAIN]} + {1'b0, slot_valid[SLOT_SKID]};
    assign first_exc            = first_exc_q;
    assign stall_cnt            = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench: directed scenarios plus random traffic, all compared
// against a depth-2 FIFO reference model kept as a queue.
module tb_pipe_stage_skid;

    localparam int W = 32;
    localparam int E = 2;
    localparam int C = 3;
    localparam int CMAX = (1 << C) - 1;

    logic         clk = 1'b0;
    logic         reset;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic [E-1:0] in_exc;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [E-1:0] out_exc;
    logic [1:0]   occupancy;
    logic [E-1:0] first_exc;
    logic [C-1:0] stall_cnt;

    always #5 clk = ~clk;

    pipe_stage_skid #(
        .WIDTH(W),
        .EXC_W(E),
        .CNT_W(C)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_exc   (in_exc),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_exc  (out_exc),
        .occupancy(occupancy),
        .first_exc(first_exc),
        .stall_cnt(stall_cnt)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: ordered entries {exc, data}, at most two held.
    logic [W+E-1:0] mq[$];
    int             m_first = 0;
    int             m_stall = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare all outputs with the model, then
    // advance the model by the handshake rules at the edge.
    task automatic step(input logic v, input logic [W-1:0] d, input logic [E-1:0] x,
                        input logic rdy, input logic fl, input logic rst);
        logic [W+E-1:0] head;
        bit             has;
        bit             acc;
        bit             ret;
        @(negedge clk);
        reset     = rst;
        flush     = fl;
        in_valid  = v;
        in_data   = d;
        in_exc    = x;
        out_ready = rdy;
        #1;
        has  = (mq.size() > 0);
        head = has ? mq[0] : '0;
        chk("out_valid", 64'(out_valid), 64'(has));
        chk("out_data", 64'(out_data), 64'(head[W-1:0]));
        chk("out_exc", 64'(out_exc), 64'(head[W+E-1:W]));
        chk("in_ready", 64'(in_ready), 64'(mq.size() < 2));
        chk("occupancy", 64'(occupancy), 64'(mq.size()));
        chk("first_exc", 64'(first_exc), 64'(m_first));
        chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
        acc = v && (mq.size() < 2) && !fl && !rst;
        ret = has && rdy && !fl && !rst;
        @(posedge clk);
        if (rst || fl) begin
            mq.delete();
            m_first = 0;
            m_stall = 0;
        end else begin
            if (has && !rdy && m_stall < CMAX) m_stall++;
            if (ret) begin
                $display("retire data=%h exc=%0d", head[W-1:0], head[W+E-1:W]);
                void'(mq.pop_front());
            end
            if (acc) begin
                mq.push_back({x, d});
                if (x != 0 && m_first == 0) m_first = int'(x);
            end
        end
    endtask

    initial begin
        // Reset held two edges while an entry is offered.
        @(negedge clk);
        reset = 1'b1; flush = 1'b0; in_valid = 1'b1;
        in_data = 32'hDEADBEEF; in_exc = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_occupancy", 64'(occupancy), 64'd0);
        chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);

        // Streaming at full rate.
        step(1'b1, 32'h10, 2'd0, 1'b1, 1'b0, 1'b0); #1 chk("stream0", 64'(out_data), 64'h10);
        step(1'b1, 32'h11, 2'd0, 1'b1, 1'b0, 1'b0); #1 chk("stream1", 64'(out_data), 64'h11);
        step(1'b1, 32'h12, 2'd0, 1'b1, 1'b0, 1'b0); #1 chk("stream2", 64'(out_data), 64'h12);
        chk("stream_ready", 64'(in_ready), 64'd1);
        step(1'b0, 32'h0, 2'd0, 1'b1, 1'b0, 1'b0);

        // Skid fill under back-pressure, then drain.
        step(1'b1, 32'hA, 2'd0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hB, 2'd0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("skid_occ", 64'(occupancy), 64'd2);
        chk("skid_ready", 64'(in_ready), 64'd0);
        chk("skid_head", 64'(out_data), 64'hA);
        step(1'b1, 32'hE, 2'd0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 2'd0, 1'b1, 1'b0, 1'b0);
        #1;
        chk("drain_head", 64'(out_data), 64'hB);
        chk("drain_ready", 64'(in_ready), 64'd1);
        step(1'b0, 32'h0, 2'd0, 1'b1, 1'b0, 1'b0);
        #1 chk("drain_occ", 64'(occupancy), 64'd0);

        // Flush with two held and one offered.
        step(1'b1, 32'h1, 2'd3, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h2, 2'd0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hC, 2'd0, 1'b1, 1'b1, 1'b0);
        #1;
        chk("flush_occ", 64'(occupancy), 64'd0);
        chk("flush_valid", 64'(out_valid), 64'd0);
        chk("flush_first", 64'(first_exc), 64'd0);
        step(1'b0, 32'h0, 2'd0, 1'b1, 1'b0, 1'b0);

        // Exception capture.
        step(1'b1, 32'h20, 2'd0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'h21, 2'd2, 1'b1, 1'b0, 1'b0); #1 chk("exc_first2", 64'(first_exc), 64'd2);
        step(1'b1, 32'h22, 2'd1, 1'b1, 1'b0, 1'b0);
        #1;
        chk("exc_sticky", 64'(first_exc), 64'd2);
        chk("exc_head", 64'(out_exc), 64'd1);
        step(1'b0, 32'h0, 2'd0, 1'b1, 1'b0, 1'b0);

        // Stall counter saturation.
        step(1'b0, 32'h0, 2'd0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 32'h30, 2'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0);
            #1 chk("sat_cnt", 64'(stall_cnt), 64'((i + 1 < CMAX) ? i + 1 : CMAX));
        end
        step(1'b0, 32'h0, 2'd0, 1'b1, 1'b0, 1'b0);

        // Random traffic with occasional flush and reset.
        for (int i = 0; i < 400; i++) begin
            step(1'(($urandom % 4) != 0),
                 $urandom,
                 (($urandom % 3) == 0) ? E'($urandom) : E'(0),
                 1'(($urandom % 3) != 0),
                 1'(($urandom % 40) == 0),
                 1'(($urandom % 100) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised, handshaked pipeline-stage register for the CPU datapath, the next generation of the fixed-field stall/flush inter-stage registers (IF_ID, ID_EX, EX_MEM, MEM_WB). It carries one opaque payload word plus an exception code through a two-entry skid buffer. Valid/ready flow control replaces the global stall wire, so upstream timing never depends combinationally on downstream ready. Flush squashes in-flight entries, a sticky first-exception register feeds the exception unit, and a saturating counter records back-pressure cycles for performance debug.

## Interface
- WIDTH, 32: payload width in bits (concatenated instruction, PCplus4, ALU result, control fields); minimum 1
- EXC_W, 2: exception-code width; code 0 means no exception
- CNT_W, 16: stall-counter width
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  synchronous squash of all held entries
- in_valid  in  1  upstream offers an entry
- in_ready  out  1  stage can accept; driven directly from a flop
- in_data  in  WIDTH  payload
- in_exc  in  EXC_W  exception code of offered entry
- out_valid  out  1  head entry valid
- out_ready  in  1  downstream accepts head
- out_data  out  WIDTH  head payload
- out_exc  out  EXC_W  head exception code
- occupancy  out  2  entries held: 0, 1 or 2
- first_exc  out  EXC_W  first non-zero exception code accepted since reset or flush; sticky
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0; saturating

## Operation
- Storage is two slots. MAIN drives out_*. SKID holds the overflow entry.
- Accept when in_valid && in_ready. Retire when out_valid && out_ready.
- MAIN empty plus accept: MAIN loads.
- MAIN full, retire, no SKID: an accept reloads MAIN; otherwise MAIN empties.
- MAIN full, no retire, accept: SKID loads.
- SKID full plus retire: MAIN takes SKID and SKID empties. in_ready is 0 whenever SKID is full, so no accept can occur that cycle.
- in_ready equals NOT SKID.valid. It is a registered signal with no combinational path from out_ready.
- first_exc loads in_exc on an accept where in_exc != 0 and first_exc == 0. Otherwise it holds.
- stall_cnt increments when out_valid && !out_ready. It saturates at 2^CNT_W-1.
- flush clears both slot valids, zeroes both slot payloads and exception codes, and clears first_exc and stall_cnt. Any in_valid offered in the flush cycle is discarded. reset has identical effect and takes priority over flush.
- Invalid slots hold zero data, so out_data and out_exc read 0 whenever out_valid=0.

## Timing
- Reset and flush values on the next edge: out_valid 0, out_data 0, out_exc 0, in_ready 1, occupancy 0, first_exc 0, stall_cnt 0.
- Latency: entry accepted at edge N is visible on out_* after edge N, i.e. out_valid=1 in cycle N+1.
- Throughput: 1 entry per cycle while out_ready stays 1.
- in_ready falls one cycle after the stall that filled SKID. It rises one cycle after the retire that drained SKID.
- Ordering is strictly FIFO. No entry is dropped or duplicated except by flush or reset.
- flush together with out_ready=1: the head is not counted as retired. Downstream ignores it because flush is also applied downstream.
- out_data and out_exc stay stable while out_valid=1 and out_ready=0.

## Structure
- Shared package cpu_pipe_pkg holds EXC_NONE (=0) and the default WIDTH and EXC_W constants, reused by all stage instances.
- One natural sub-module, pipe_slot: a valid bit plus a WIDTH+EXC_W data register with load, clear (reset/flush) and hold. It is instantiated twice, as MAIN and SKID.
- Top-level logic is the slot-control decode, the in_ready flop, first_exc and stall_cnt.

## Test plan
- Reset/flush values: hold reset for 2 cycles with in_valid=1 and in_data=0xDEADBEEF. Expect out_valid=0, out_data=0, in_ready=1, occupancy=0 and stall_cnt=0 after the release edge.
- Streaming: out_ready=1, push 0x10,0x11,0x12 back-to-back. Expect out_data 0x10,0x11,0x12 in cycles 1,2,3, with in_ready never 0.
- Skid fill: push 0xA then 0xB with out_ready=0. Expect occupancy=2, in_ready=0 from the following cycle, out_data=0xA held and stall_cnt counting. Raise out_ready. Expect 0xA then 0xB, in_ready=1 one cycle after the 0xA retire, then occupancy=0.
- Flush mid-operation: with occupancy=2, assert flush alongside in_valid=1 and in_data=0xC. Expect occupancy=0, out_valid=0, 0xC never emitted and first_exc=0.
- Exception capture: push in_exc 0,2,1. Expect first_exc=2 after the second accept, still 2 after the third, and out_exc 0,2,1 in order.
- Counter saturation: CNT_W=3, out_valid=1, out_ready=0 for 10 cycles. Expect stall_cnt 1..7, then holding at 7.
